// File: rtl/aes_frame_ctrl.sv
// Frame controller between the SPI slave and an AES-128 core: accepts a key/plaintext
// frame, runs one encryption via start/done, and holds the ciphertext until acknowledged.
module aes_frame_ctrl #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int TW             = 11
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         frame_valid,
  input  logic [255:0] frame_data,
  output logic         frame_ready,
  output logic         aes_start,
  output logic [127:0] aes_key,
  output logic [127:0] aes_block,
  input  logic         aes_done,
  input  logic [127:0] aes_result,
  output logic         result_valid,
  output logic [127:0] result_data,
  input  logic         result_ack,
  output logic         busy,
  output logic         err_overrun,
  output logic         err_timeout,
  input  logic         err_clr,
  output logic [7:0]   frame_count
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_HOLD = 2'd3;

  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [1:0]    state_reg, state_next;
  logic [TW-1:0] timer_reg, timer_next;
  logic [127:0]  key_reg, key_next;
  logic [127:0]  block_reg, block_next;
  logic [127:0]  data_reg, data_next;
  logic          valid_reg, valid_next;
  logic [7:0]    count_reg, count_next;
  logic          ready_reg, start_reg, busy_reg;
  logic          ovr_reg, tmo_reg;
  logic          ovr_set, tmo_set;

  always_comb begin
    state_next = state_reg;
    timer_next = timer_reg;
    key_next   = key_reg;
    block_next = block_reg;
    data_next  = data_reg;
    valid_next = valid_reg;
    count_next = count_reg;
    tmo_set    = 1'b0;
    // Any frame that shows up outside IDLE is dropped and only flagged.
    ovr_set    = frame_valid && (state_reg != S_IDLE);
    case (state_reg)
      S_IDLE: begin
        if (frame_valid) begin
          key_next   = frame_data[255:128];
          block_next = frame_data[127:0];
          timer_next = '0;
          state_next = S_LOAD;
        end
      end
      S_LOAD: state_next = S_RUN;
      S_RUN: begin
        // A done arriving on the expiry cycle takes priority over the timeout.
        if (aes_done) begin
          data_next  = aes_result;
          valid_next = 1'b1;
          state_next = S_HOLD;
        end else if (timer_reg == TIMER_LAST) begin
          tmo_set    = 1'b1;
          state_next = S_IDLE;
        end else begin
          timer_next = timer_reg + 1'b1;
        end
      end
      default: begin
        if (result_ack) begin
          valid_next = 1'b0;
          count_next = count_reg + 8'd1;
          state_next = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_IDLE;
      timer_reg <= '0;
      key_reg   <= '0;
      block_reg <= '0;
      data_reg  <= '0;
      valid_reg <= 1'b0;
      count_reg <= '0;
      ready_reg <= 1'b1;
      start_reg <= 1'b0;
      busy_reg  <= 1'b0;
      ovr_reg   <= 1'b0;
      tmo_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      timer_reg <= timer_next;
      key_reg   <= key_next;
      block_reg <= block_next;
      data_reg  <= data_next;
      valid_reg <= valid_next;
      count_reg <= count_next;
      ready_reg <= (state_next == S_IDLE);
      start_reg <= (state_next == S_LOAD);
      busy_reg  <= (state_next != S_IDLE);
      // Sticky flags: a new event in the clearing cycle still sets the flag.
      ovr_reg   <= ovr_set || (ovr_reg && !err_clr);
      tmo_reg   <= tmo_set || (tmo_reg && !err_clr);
    end
  end

  assign frame_ready  = ready_reg;
  assign aes_start    = start_reg;
  assign aes_key      = key_reg;
  assign aes_block    = block_reg;
  assign result_valid = valid_reg;
  assign result_data  = data_reg;
  assign busy         = busy_reg;
  assign err_overrun  = ovr_reg;
  assign err_timeout  = tmo_reg;
  assign frame_count  = count_reg;

endmodule

// File: tb/tb_aes_frame_ctrl.sv
// Self-checking bench for aes_frame_ctrl: directed vectors, timeout cases on a short-timeout
// instance, reset abort, and 256 randomized frames checked against a transaction-level model.
module tb_aes_frame_ctrl;

  logic         clk = 1'b0;
  logic         rst, frame_valid, aes_done, result_ack, err_clr, en8;
  logic [255:0] frame_data;
  logic [127:0] aes_result;

  logic         frame_ready, aes_start, result_valid, busy, err_overrun, err_timeout;
  logic [127:0] aes_key, aes_block, result_data;
  logic [7:0]   frame_count;

  logic         ready_t, start_t, rv_t, busy_t, ovr_t, tmo_t;
  logic [127:0] key_t, block_t, rd_t;
  logic [7:0]   count_t;
  logic         rst8;

  int checks = 0;
  int errors = 0;

  // transaction-level expectations
  logic [127:0] m_key, m_block, m_data;
  logic [7:0]   m_count;
  logic         m_ovr, m_tmo;
  int           frame_no = 0;

  always #5 clk = ~clk;
  assign rst8 = rst || !en8;

  aes_frame_ctrl dut (
    .clk(clk), .rst(rst), .frame_valid(frame_valid), .frame_data(frame_data),
    .frame_ready(frame_ready), .aes_start(aes_start), .aes_key(aes_key), .aes_block(aes_block),
    .aes_done(aes_done), .aes_result(aes_result), .result_valid(result_valid),
    .result_data(result_data), .result_ack(result_ack), .busy(busy),
    .err_overrun(err_overrun), .err_timeout(err_timeout), .err_clr(err_clr),
    .frame_count(frame_count)
  );

  aes_frame_ctrl #(.TIMEOUT_CYCLES(8), .TW(3)) dut8 (
    .clk(clk), .rst(rst8), .frame_valid(frame_valid), .frame_data(frame_data),
    .frame_ready(ready_t), .aes_start(start_t), .aes_key(key_t), .aes_block(block_t),
    .aes_done(aes_done), .aes_result(aes_result), .result_valid(rv_t),
    .result_data(rd_t), .result_ack(result_ack), .busy(busy_t),
    .err_overrun(ovr_t), .err_timeout(tmo_t), .err_clr(err_clr),
    .frame_count(count_t)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic model_reset();
    m_key = '0; m_block = '0; m_data = '0; m_count = '0; m_ovr = 1'b0; m_tmo = 1'b0;
  endtask

  task automatic chk_reset_state();
    chk("rst_ready", frame_ready, 1);
    chk("rst_start", aes_start, 0);
    chk("rst_key", aes_key, 0);
    chk("rst_block", aes_block, 0);
    chk("rst_rv", result_valid, 0);
    chk("rst_rd", result_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ovr", err_overrun, 0);
    chk("rst_tmo", err_timeout, 0);
    chk("rst_count", frame_count, 0);
  endtask

  // One complete frame: d = RUN cycles before aes_done, ack_dly = HOLD cycles before ack.
  task automatic do_frame(input logic [127:0] key, input logic [127:0] pt, input logic [127:0] ct,
                          input int d, input int ack_dly, input bit inj_run, input bit inj_hold);
    chk("ready_idle", frame_ready, 1);
    frame_data = {key, pt};
    frame_valid = 1'b1;
    tick();
    frame_valid = 1'b0;
    m_key = key;
    m_block = pt;
    chk("start_pulse", aes_start, 1);
    chk("key_latch", aes_key, m_key);
    chk("block_latch", aes_block, m_block);
    chk("busy_load", busy, 1);
    chk("ready_load", frame_ready, 0);
    tick();
    chk("start_once", aes_start, 0);
    for (int i = 0; i < d; i++) begin
      if (inj_run && i == d / 2) begin
        frame_valid = 1'b1;
        frame_data = {rnd128(), rnd128()};
        err_clr = 1'($urandom_range(0, 1));
        m_ovr = 1'b1;
      end
      tick();
      frame_valid = 1'b0;
      err_clr = 1'b0;
      chk("no_restart", aes_start, 0);
      chk("rv_run", result_valid, 0);
      chk("key_hold", aes_key, m_key);
    end
    aes_done = 1'b1;
    aes_result = ct;
    tick();
    aes_done = 1'b0;
    aes_result = rnd128();
    m_data = ct;
    chk("rv_set", result_valid, 1);
    chk("rd_set", result_data, m_data);
    chk("ready_hold", frame_ready, 0);
    for (int i = 0; i < ack_dly; i++) begin
      tick();
      chk("rv_stable", result_valid, 1);
      chk("rd_stable", result_data, m_data);
    end
    result_ack = 1'b1;
    if (inj_hold) begin
      frame_valid = 1'b1;
      frame_data = {rnd128(), rnd128()};
      m_ovr = 1'b1;
    end
    tick();
    result_ack = 1'b0;
    frame_valid = 1'b0;
    m_count = m_count + 8'd1;
    chk("rv_clear", result_valid, 0);
    chk("ready_after_ack", frame_ready, 1);
    chk("busy_after_ack", busy, 0);
    chk("count", frame_count, m_count);
    chk("overrun", err_overrun, m_ovr);
    chk("timeout_main", err_timeout, m_tmo);
    chk("key_after", aes_key, m_key);
    chk("rd_kept", result_data, m_data);
    $display("frame %0d key=%h ct=%h run=%0d ack=%0d ovr=%0d/%0d count=%0d",
             frame_no, key, ct, d, ack_dly, inj_run, inj_hold, frame_count);
    frame_no++;
  endtask

  task automatic clear_errors();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    m_ovr = 1'b0;
    m_tmo = 1'b0;
    chk("clr_ovr", err_overrun, 0);
    chk("clr_tmo", err_timeout, 0);
  endtask

  initial begin
    rst = 1'b1; en8 = 1'b0; frame_valid = 1'b0; frame_data = '0; aes_done = 1'b0;
    aes_result = '0; result_ack = 1'b0; err_clr = 1'b0;
    model_reset();
    tick();
    tick();
    rst = 1'b0;
    chk_reset_state();

    // known-answer frame, 10-cycle core latency, 50-cycle ack wait
    do_frame(128'h000102030405060708090a0b0c0d0e0f, 128'h00112233445566778899aabbccddeeff,
             128'h69c4e0d86a7b0430d8cdb78070b4c55a, 9, 50, 1'b0, 1'b0);
    // overrun during RUN and during HOLD alongside ack
    do_frame(rnd128(), rnd128(), rnd128(), 6, 3, 1'b1, 1'b1);
    clear_errors();
    do_frame(rnd128(), rnd128(), rnd128(), 0, 0, 1'b0, 1'b0);

    // reset in RUN aborts; a late aes_done is ignored
    frame_valid = 1'b1;
    frame_data = {rnd128(), rnd128()};
    tick();
    frame_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_reset();
    chk_reset_state();
    aes_done = 1'b1;
    aes_result = rnd128();
    tick();
    aes_done = 1'b0;
    chk("late_done_rv", result_valid, 0);
    chk("late_done_ready", frame_ready, 1);

    // timeout cases on the 8-cycle instance
    en8 = 1'b1;
    tick();
    chk("t_ready", ready_t, 1);
    frame_valid = 1'b1;
    frame_data = {rnd128(), rnd128()};
    tick();
    frame_valid = 1'b0;
    chk("t_start", start_t, 1);
    tick();
    for (int i = 1; i <= 8; i++) begin
      tick();
      chk("t_tmo_timing", tmo_t, (i == 8));
      chk("t_ready_timing", ready_t, (i == 8));
      chk("t_rv_never", rv_t, 0);
    end
    aes_done = 1'b1;
    aes_result = rnd128();
    tick();
    aes_done = 1'b0;
    chk("t_done_ignored", rv_t, 0);
    chk("t_idle_kept", ready_t, 1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("t_tmo_clr", tmo_t, 0);
    $display("timeout case: err_timeout after 8 RUN cycles");

    frame_valid = 1'b1;
    frame_data = {rnd128(), rnd128()};
    tick();
    frame_valid = 1'b0;
    tick();
    for (int i = 0; i < 7; i++) tick();
    aes_done = 1'b1;
    aes_result = 128'hdeadbeef_0badf00d_12345678_9abcdef0;
    tick();
    aes_done = 1'b0;
    chk("t_edge_rv", rv_t, 1);
    chk("t_edge_rd", rd_t, 128'hdeadbeef_0badf00d_12345678_9abcdef0);
    chk("t_edge_tmo", tmo_t, 0);
    tick();
    chk("t_edge_tmo2", tmo_t, 0);
    result_ack = 1'b1;
    tick();
    result_ack = 1'b0;
    chk("t_edge_ack", rv_t, 0);
    chk("t_edge_count", count_t, 1);
    $display("timeout case: done on expiry cycle wins");

    en8 = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_reset();
    chk_reset_state();

    // 256 randomized frames; frame_count must wrap back to 0
    for (int n = 0; n < 256; n++) begin
      if ($urandom_range(0, 7) == 0) clear_errors();
      do_frame(rnd128(), rnd128(), rnd128(), $urandom_range(0, 12), $urandom_range(0, 4),
               ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0));
    end
    chk("count_wrap", frame_count, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
